// File: rtl/num_sync_filt.sv
// num_sync_filt: per-channel flop-chain synchroniser plus stability filter with one-cycle change strobes; optional hold_i gated by NUM_SYNC_FILT_HOLD_EN
module num_sync_filt #(
   parameter int CH_CNT     = 6,
   parameter int NUM_W      = 3,
   parameter int SYNC_D     = 3,
   parameter int STABLE_CNT = 4
)(
   input  logic                    clk_sync_i,
   input  logic                    rst_n_i,
   input  logic [CH_CNT*NUM_W-1:0] num_i,
`ifdef NUM_SYNC_FILT_HOLD_EN
   input  logic                    hold_i,
`endif
   output logic [CH_CNT*NUM_W-1:0] sync_num_o,
   output logic [CH_CNT-1:0]       changed_o,
   output logic                    any_changed_o
);
   localparam int CW = $clog2(STABLE_CNT) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);
   logic hold;
`ifdef NUM_SYNC_FILT_HOLD_EN
   assign hold = hold_i;
`else
   assign hold = 1'b0;
`endif
   for (genvar k = 0; k < CH_CNT; k++) begin : g_ch
      logic [SYNC_D-1:0][NUM_W-1:0] chain;
      logic [NUM_W-1:0]             cand;
      logic [NUM_W-1:0]             s;
      logic [NUM_W-1:0]             out;
      logic [CW-1:0]                cnt;
      logic                         chg;
      assign s = chain[SYNC_D-1];
      assign sync_num_o[k*NUM_W +: NUM_W] = out;
      assign changed_o[k] = chg;
      // synchronise, then publish a candidate only once it has stayed put long enough
      always_ff @(posedge clk_sync_i or negedge rst_n_i)
         if (!rst_n_i) begin
            chain <= '0;
            cand  <= '0;
            cnt   <= '0;
            out   <= '0;
            chg   <= 1'b0;
         end else begin
            chain <= {chain[SYNC_D-2:0], num_i[k*NUM_W +: NUM_W]};
            chg   <= 1'b0;
            if (s != cand) begin
               cand <= s;
               cnt  <= '0;
            end else if (cnt != CNT_MAX)
               cnt <= cnt + 1'b1;
            else if (cand != out && !hold) begin
               out <= cand;
               chg <= 1'b1;
            end
         end
   end
   assign any_changed_o = |changed_o;
endmodule

// File: tb/tb_num_sync_filt.sv
// tb_num_sync_filt: directed stimulus with a strobe scoreboard for num_sync_filt at default parameters
module tb_num_sync_filt;
   logic        clk_sync_i = 1'b0;
   logic        rst_n_i;
   logic [17:0] num_i;
`ifdef NUM_SYNC_FILT_HOLD_EN
   logic        hold_i;
`endif
   logic [17:0] sync_num_o;
   logic [5:0]  changed_o;
   logic        any_changed_o;

   typedef struct {int edg; logic [17:0] num; logic [5:0] chg;} exp_t;
   exp_t q[$];
   exp_t cur;
   int edge_n = 0;
   int n_vec  = 0;
   int n_err  = 0;
   int b;

   num_sync_filt dut (
      .clk_sync_i   (clk_sync_i),
      .rst_n_i      (rst_n_i),
      .num_i        (num_i),
`ifdef NUM_SYNC_FILT_HOLD_EN
      .hold_i       (hold_i),
`endif
      .sync_num_o   (sync_num_o),
      .changed_o    (changed_o),
      .any_changed_o(any_changed_o)
   );

   always #5 clk_sync_i = ~clk_sync_i;

   // count rising edges so expectations can name an absolute edge
   always @(posedge clk_sync_i) edge_n++;

   function automatic logic [17:0] pk(input logic [2:0] c5, c4, c3, c2, c1, c0);
      return {c5, c4, c3, c2, c1, c0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h want %0h", nm, edge_n, act, exp);
      end
   endtask

   task automatic expect_at(input int e, input logic [17:0] n, input logic [5:0] c);
      q.push_back('{e, n, c});
   endtask

   // scoreboard: every strobe must match the oldest pending expectation
   always @(negedge clk_sync_i) begin
      while (q.size() > 0 && q[0].edg < edge_n) begin
         n_vec++;
         n_err++;
         $display("FAIL missed_strobe: no strobe by edge %0d, want chg=%b num=%0h at edge %0d", edge_n, q[0].chg, q[0].num, q[0].edg);
         void'(q.pop_front());
      end
      if (any_changed_o) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe at edge %0d: chg=%b num=%0h want none", edge_n, changed_o, sync_num_o);
         end else begin
            cur = q.pop_front();
            chk("strobe_edge", edge_n, cur.edg);
            chk("strobe_mask", {26'd0, changed_o}, {26'd0, cur.chg});
            chk("strobe_value", {14'd0, sync_num_o}, {14'd0, cur.num});
         end
      end
   end

   initial begin
      rst_n_i = 1'b0;
      num_i   = pk(5, 5, 5, 5, 5, 5);
`ifdef NUM_SYNC_FILT_HOLD_EN
      hold_i  = 1'b0;
`endif
      repeat (3) @(negedge clk_sync_i);
      chk("rst_num", {14'd0, sync_num_o}, 0);
      chk("rst_chg", {26'd0, changed_o}, 0);
      rst_n_i = 1'b1;
      b = edge_n;
      expect_at(b + 8, pk(5, 5, 5, 5, 5, 5), 6'b111111);
      repeat (7) @(negedge clk_sync_i);
      chk("rel_pre_num", {14'd0, sync_num_o}, 0);
      repeat (13) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 0, 0, 0);
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 0, 0, 0, 0), 6'b111111);
      repeat (16) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 3, 0, 0);
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 0, 3, 0, 0), 6'b000100);
      repeat (7) @(negedge clk_sync_i);
      chk("step_pre_num", {14'd0, sync_num_o}, 0);
      repeat (9) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 3, 0, 1);
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 0, 3, 0, 1), 6'b000001);
      repeat (16) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 3, 0, 6);
      repeat (3) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 3, 0, 1);
      repeat (16) @(negedge clk_sync_i);
      chk("glitch_reject", {14'd0, sync_num_o}, {14'd0, pk(0, 0, 0, 3, 0, 1)});
      num_i = pk(0, 0, 0, 3, 0, 6);
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 0, 3, 0, 6), 6'b000001);
      expect_at(b + 13, pk(0, 0, 0, 3, 0, 1), 6'b000001);
      repeat (5) @(negedge clk_sync_i);
      num_i = pk(0, 0, 0, 3, 0, 1);
      repeat (20) @(negedge clk_sync_i);
      num_i = pk(0, 7, 0, 3, 2, 1);
      b = edge_n;
      expect_at(b + 8, pk(0, 7, 0, 3, 2, 1), 6'b010010);
      repeat (10) @(negedge clk_sync_i);
      for (int i = 0; i < 10; i++) begin
         num_i = pk(0, (i % 2 == 0) ? 3'd0 : 3'd7, 0, 3, 2, 1);
         repeat (2) @(negedge clk_sync_i);
      end
      repeat (16) @(negedge clk_sync_i);
      chk("indep_hold", {14'd0, sync_num_o}, {14'd0, pk(0, 7, 0, 3, 2, 1)});
      num_i = pk(0, 0, 0, 0, 0, 0);
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 0, 0, 0, 0), 6'b010111);
      repeat (16) @(negedge clk_sync_i);
      num_i = pk(0, 0, 4, 0, 0, 0);
      repeat (4) @(negedge clk_sync_i);
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk_sync_i);
      chk("midrst_num", {14'd0, sync_num_o}, 0);
      rst_n_i = 1'b1;
      b = edge_n;
      expect_at(b + 8, pk(0, 0, 4, 0, 0, 0), 6'b001000);
      repeat (7) @(negedge clk_sync_i);
      chk("midrst_pre_num", {14'd0, sync_num_o}, 0);
      repeat (10) @(negedge clk_sync_i);
`ifdef NUM_SYNC_FILT_HOLD_EN
      hold_i = 1'b1;
      num_i  = pk(1, 0, 4, 0, 0, 0);
      repeat (20) @(negedge clk_sync_i);
      chk("hold_frozen", {14'd0, sync_num_o}, {14'd0, pk(0, 0, 4, 0, 0, 0)});
      hold_i = 1'b0;
      b = edge_n;
      expect_at(b + 1, pk(1, 0, 4, 0, 0, 0), 6'b100000);
      repeat (6) @(negedge clk_sync_i);
`endif
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
